imem_loader: RTL

//  Writer for the instruction memory that the fetch stage reads. Accepts a byte stream over a

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_word_packer.sv | 36 +++
 rtl/imem_loader.sv | 85 ++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: FSM state encodings, byte-index width and byte-lane helper shared by the loader,
// its word packer and the fetch-side hold logic.
package imem_loader_pkg;
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_WRITE = 3'd2;
   localparam state_t ST_DONE  = 3'd3;
   localparam state_t ST_ERR   = 3'd4;
   localparam int BYTE_IDX_W = 2;
   // Big-endian lane: byte k of a word occupies bits [31-8k -: 8], i.e. lsb at 24-8k.
   function automatic logic [4:0] byte_lsb(input logic [BYTE_IDX_W-1:0] k);
      return 5'd24 - {k, 3'b000};
   endfunction
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs accepted bytes big-endian into a 32-bit word.
//   clk, rst   clock, asynchronous active-high reset
//   clr        zero the pack register and byte index (wins over load_byte)
//   load_byte  byte_in is accepted this cycle
//   byte_in    stream byte
//   word       packed word including the byte accepted this cycle
//   word_full  the byte accepted this cycle completes the word
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        load_byte,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);
   logic [BYTE_IDX_W-1:0] idx;
   logic [31:0]           pack_q;
   // Unfilled lanes are always zero, so OR-ing the new byte in is enough.
   assign word      = load_byte ? (pack_q | ({24'h0, byte_in} << byte_lsb(idx))) : pack_q;
   assign word_full = idx == '1;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= '0;
         pack_q <= '0;
      end else if (clr) begin
         idx    <= '0;
         pack_q <= '0;
      end else if (load_byte) begin
         idx    <= idx + 1'b1;
         pack_q <= word;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction memory as big-endian 32-bit words, holding the CPU while loading.
//   clk, rst                          clock, asynchronous active-high reset
//   start                             begin a new load (honoured in IDLE/DONE/ERR)
//   byte_in, byte_valid, byte_last    byte stream, byte_ready is the registered accept side
//   imem_we, imem_addr, imem_wdata    one-cycle word write; address/data hold when idle
//   cpu_hold                          low only once a load has completed
//   done, error                       load complete / overflow abort levels
//   word_count                        words written in the current or last load
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 7,
   parameter int BASE_ADDR  = 0,
   parameter int MAX_WORDS  = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            byte_in,
   input  logic                  byte_valid,
   input  logic                  byte_last,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count
);
   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0]   MAX_W  = (ADDR_WIDTH + 1)'(MAX_WORDS);
   state_t      state, state_nxt;
   logic        last_q, accept, ovf, restart, clr, load_byte, word_full;
   logic [31:0] word;
   assign accept    = byte_valid & byte_ready;
   assign ovf       = word_count == MAX_W;
   assign restart   = start & (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
   // The overflowing byte is dropped and never reaches the packer.
   assign load_byte = accept & ~ovf;
   assign clr       = restart | (state == ST_WRITE);
   imem_word_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .load_byte (load_byte),
      .byte_in   (byte_in),
      .word      (word),
      .word_full (word_full)
   );
   always_comb begin
      state_nxt = restart                        ? ST_LOAD :
                  (state == ST_LOAD && accept)   ? (ovf ? ST_ERR : (word_full | byte_last) ? ST_WRITE : ST_LOAD) :
                  (state == ST_WRITE)            ? (last_q ? ST_DONE : ST_LOAD) :
                  (state > ST_ERR)               ? ST_IDLE : state;
   end
   // Every status output is registered from the next state so it is valid for the whole state cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         word_count <= '0;
         last_q     <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_ready <= state_nxt == ST_LOAD;
         imem_we    <= state_nxt == ST_WRITE;
         cpu_hold   <= state_nxt != ST_DONE;
         done       <= state_nxt == ST_DONE;
         error      <= state_nxt == ST_ERR;
         if (state_nxt == ST_WRITE) begin
            imem_addr  <= BASE_A + word_count[ADDR_WIDTH-1:0];
            imem_wdata <= word;
            last_q     <= byte_last;
         end
         word_count <= restart ? '0 : (state == ST_WRITE) ? word_count + 1'b1 : word_count;
      end
   end
endmodule
